// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine. A CPU write to the source register latches a page. A two-stage
// start sequencer (pend -> arm) then launches a copy of LEN bytes from
// {page,8'h00} into OAM, one byte per M-cycle tick.
module oam_dma_ctrl #(
  parameter int unsigned LEN      = 160,
  parameter logic [15:0] REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mcyc_ce,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  reg_dout,
  output logic        reg_sel,
  output logic        dma_run,
  output logic [15:0] dma_a,
  output logic        dma_wr,
  output logic        vram_to_oam,
  output logic        oam_addr_ndma
);

  localparam logic [7:0] LastLow = 8'(LEN - 1);

  logic [7:0] src_q, src_d;
  logic [7:0] act_hi_q, act_hi_d;
  logic [7:0] low_q, low_d;
  logic       pend_q, pend_d;
  logic       arm_q, arm_d;
  logic       run_q, run_d;
  logic       reg_wr;

  assign reg_wr = cpu_wr && (a == REG_ADDR);

  // Next-state: start sequencer, byte counter and register write.
  always_comb begin
    src_d    = src_q;
    act_hi_d = act_hi_q;
    low_d    = low_q;
    pend_d   = pend_q;
    arm_d    = arm_q;
    run_d    = run_q;
    if (mcyc_ce) begin
      // Current byte is committed this tick; advance or finish.
      if (run_q) begin
        if (low_q == LastLow) begin
          run_d = 1'b0;
        end else begin
          low_d = low_q + 8'd1;
        end
      end
      // Arm reloads the transfer and overrides a simultaneous end of run.
      if (arm_q) begin
        act_hi_d = src_q;
        low_d    = 8'd0;
        run_d    = 1'b1;
      end
      arm_d  = pend_q;
      pend_d = 1'b0;
    end
    // A write lands after the ce decision, so a same-clk tick does not see it.
    if (reg_wr) begin
      src_d  = d;
      pend_d = 1'b1;
    end
  end

  // State registers with synchronous reset that overrides ce and writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= 8'd0;
      act_hi_q <= 8'd0;
      low_q    <= 8'd0;
      pend_q   <= 1'b0;
      arm_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      src_q    <= src_d;
      act_hi_q <= act_hi_d;
      low_q    <= low_d;
      pend_q   <= pend_d;
      arm_q    <= arm_d;
      run_q    <= run_d;
    end
  end

  // Outputs decoded from registered state for the OAM address/data mux.
  always_comb begin
    reg_dout      = src_q;
    reg_sel       = (a == REG_ADDR) && cpu_rd;
    dma_run       = run_q;
    dma_a         = {act_hi_q, low_q};
    dma_wr        = run_q && mcyc_ce;
    vram_to_oam   = (act_hi_q[7:5] == 3'b100) && run_q;
    oam_addr_ndma = !run_q;
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  localparam logic [15:0] RegAddr = 16'hFF46;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mcyc_ce = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d = 8'h00;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  reg_dout;
  logic        reg_sel;
  logic        dma_run;
  logic [15:0] dma_a;
  logic        dma_wr;
  logic        vram_to_oam;
  logic        oam_addr_ndma;

  typedef struct packed {
    logic [15:0] addr;
    logic        vram;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  oam_dma_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .mcyc_ce      (mcyc_ce),
    .a            (a),
    .d            (d),
    .cpu_wr       (cpu_wr),
    .cpu_rd       (cpu_rd),
    .reg_dout     (reg_dout),
    .reg_sel      (reg_sel),
    .dma_run      (dma_run),
    .dma_a        (dma_a),
    .dma_wr       (dma_wr),
    .vram_to_oam  (vram_to_oam),
    .oam_addr_ndma(oam_addr_ndma)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every committed OAM byte must match the next scoreboard entry.
  always @(negedge clk) begin
    if (dma_wr === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_dma_wr: got addr %0h expected no write", dma_a);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("dma_a", {16'h0, dma_a}, {16'h0, e.addr});
        check("vram_to_oam", {31'h0, vram_to_oam}, {31'h0, e.vram});
        check("ndma_during_run", {31'h0, oam_addr_ndma}, 32'h0);
      end
    end
  end

  // Expected commits for bytes first..last of a page.
  task automatic push_run(input logic [7:0] page, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      exp_t e;
      e.addr = {page, 8'(i)};
      e.vram = (page[7:5] == 3'b100);
      sb_q.push_back(e);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic ce_tick(input int gap);
    mcyc_ce = 1'b1;
    @(posedge clk); #1;
    mcyc_ce = 1'b0;
    for (int i = 1; i < gap; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic cpu_write(input logic [7:0] val);
    a      = RegAddr;
    d      = val;
    cpu_wr = 1'b1;
    @(posedge clk); #1;
    cpu_wr = 1'b0;
    a      = 16'h0000;
  endtask

  task automatic drained(input string name);
    check(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    int ok;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_run", {31'h0, dma_run}, 32'h0);
    check("rst_dma_a", {16'h0, dma_a}, 32'h0);
    check("rst_ndma", {31'h0, oam_addr_ndma}, 32'h1);
    check("rst_vram", {31'h0, vram_to_oam}, 32'h0);
    check("rst_reg_dout", {24'h0, reg_dout}, 32'h0);

    // 1) Basic transfer from C1, ce every 4 clk
    cpu_write(8'hC1);
    check("t1_reg_dout", {24'h0, reg_dout}, 32'hC1);
    ce_tick(4);
    check("t1_run_tick1", {31'h0, dma_run}, 32'h0);
    ce_tick(4);
    check("t1_run_tick2", {31'h0, dma_run}, 32'h1);
    check("t1_first_addr", {16'h0, dma_a}, 32'hC100);
    push_run(8'hC1, 0, 159);
    for (int i = 0; i < 159; i++) ce_tick(4);
    check("t1_run_before_last", {31'h0, dma_run}, 32'h1);
    ce_tick(4);
    check("t1_run_end", {31'h0, dma_run}, 32'h0);
    check("t1_hold_addr", {16'h0, dma_a}, 32'hC19F);
    ce_tick(4);
    check("t1_hold_addr2", {16'h0, dma_a}, 32'hC19F);
    drained("t1_drained");

    // 2) VRAM source
    cpu_write(8'h80);
    ce_tick(2);
    ce_tick(2);
    check("t2_ndma_run", {31'h0, oam_addr_ndma}, 32'h0);
    check("t2_vram_run", {31'h0, vram_to_oam}, 32'h1);
    push_run(8'h80, 0, 159);
    for (int i = 0; i < 160; i++) ce_tick(2);
    check("t2_ndma_after", {31'h0, oam_addr_ndma}, 32'h1);
    check("t2_vram_after", {31'h0, vram_to_oam}, 32'h0);
    drained("t2_drained");

    // 3) Restart mid-transfer at low=0x50
    cpu_write(8'hC0);
    ce_tick(3);
    ce_tick(3);
    push_run(8'hC0, 0, 16'h51);
    push_run(8'hD0, 0, 159);
    for (int i = 0; i < 16'h50; i++) ce_tick(3);
    check("t3_low50", {16'h0, dma_a}, 32'hC050);
    cpu_write(8'hD0);
    ok = 1;
    for (int i = 0; i < 2 + 159; i++) begin
      ce_tick(3);
      if (dma_run !== 1'b1) ok = 0;
      if (i == 1) check("t3_reload", {16'h0, dma_a}, 32'hD000);
    end
    check("t3_no_gap", ok, 1);
    ce_tick(3);
    check("t3_run_end", {31'h0, dma_run}, 32'h0);
    check("t3_hold_addr", {16'h0, dma_a}, 32'hD09F);
    drained("t3_drained");

    // 4) Arm fires on the old transfer's last tick
    cpu_write(8'hC4);
    ce_tick(2);
    ce_tick(2);
    push_run(8'hC4, 0, 159);
    push_run(8'hC5, 0, 159);
    for (int i = 0; i < 16'h9E; i++) ce_tick(2);
    cpu_write(8'hC5);
    ce_tick(2);
    check("t4_old_last", {16'h0, dma_a}, 32'hC49F);
    ce_tick(2);
    check("t4_run_kept", {31'h0, dma_run}, 32'h1);
    check("t4_new_addr", {16'h0, dma_a}, 32'hC500);
    for (int i = 0; i < 160; i++) ce_tick(2);
    check("t4_run_end", {31'h0, dma_run}, 32'h0);
    drained("t4_drained");

    // 5) Reset at low=0x20 aborts at once
    cpu_write(8'hC2);
    ce_tick(2);
    ce_tick(2);
    push_run(8'hC2, 0, 16'h1F);
    for (int i = 0; i < 16'h20; i++) ce_tick(2);
    check("t5_at_20", {16'h0, dma_a}, 32'hC220);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_run", {31'h0, dma_run}, 32'h0);
    check("t5_dma_a", {16'h0, dma_a}, 32'h0);
    check("t5_reg_dout", {24'h0, reg_dout}, 32'h0);
    check("t5_ndma", {31'h0, oam_addr_ndma}, 32'h1);
    for (int i = 0; i < 6; i++) ce_tick(2);
    check("t5_still_idle", {31'h0, dma_run}, 32'h0);
    drained("t5_drained");

    // 6) Readback, no progress without ce, then ce held high every clk
    cpu_write(8'h5A);
    a      = RegAddr;
    cpu_rd = 1'b1;
    #1;
    check("t6_reg_sel", {31'h0, reg_sel}, 32'h1);
    check("t6_reg_dout", {24'h0, reg_dout}, 32'h5A);
    a = 16'hFF47;
    #1;
    check("t6_reg_sel_other", {31'h0, reg_sel}, 32'h0);
    a = RegAddr;
    cpu_rd = 1'b0;
    #1;
    check("t6_reg_sel_nord", {31'h0, reg_sel}, 32'h0);
    a = 16'h0000;
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_ce_idle", {31'h0, dma_run}, 32'h0);
    ce_tick(1);
    check("t6_one_tick_idle", {31'h0, dma_run}, 32'h0);
    ce_tick(1);
    check("t6_started", {16'h0, dma_a}, 32'h5A00);
    push_run(8'h5A, 0, 159);
    for (int i = 0; i < 160; i++) ce_tick(1);
    check("t6_run_end", {31'h0, dma_run}, 32'h0);
    check("t6_hold_addr", {16'h0, dma_a}, 32'h5A9F);
    drained("t6_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
